// File: rtl/d_line_mem_resp_if.sv
// ---------------------------------------------------------------------------
// d_line_mem_resp_if
//
// Miss/fill bus between the data-cache controller (master) and the backing
// line memory (slave).
//
// Signals (master -> slave):
//   r_mem_req_in    line read request, level, held until completion
//   w_mem_req_in    write request, level, held until completion
//   mem_addr_in     line address
//   blockoffset_in  word select within the line (writes only)
//   byte_off_in     byte offset within the word (writes only)
//   byte_en_in      00 byte, 01 half, 10 word, 11 no-op
//   wr_data_in      write data, right-justified
// Signals (slave -> master):
//   mem_busy_out    responder not idle
//   mem_comp_out    one-cycle completion pulse
//   mem_data_out    last line read, word0 = [31:0]
// ---------------------------------------------------------------------------
interface d_line_mem_resp_if #(
    parameter int LINE_AW = 8
);
    logic               r_mem_req_in;
    logic               w_mem_req_in;
    logic [LINE_AW-1:0] mem_addr_in;
    logic [1:0]         blockoffset_in;
    logic [1:0]         byte_off_in;
    logic [1:0]         byte_en_in;
    logic [31:0]        wr_data_in;
    logic               mem_busy_out;
    logic               mem_comp_out;
    logic [127:0]       mem_data_out;

    modport master (
        output r_mem_req_in, w_mem_req_in, mem_addr_in, blockoffset_in,
               byte_off_in, byte_en_in, wr_data_in,
        input  mem_busy_out, mem_comp_out, mem_data_out
    );

    modport slave (
        input  r_mem_req_in, w_mem_req_in, mem_addr_in, blockoffset_in,
               byte_off_in, byte_en_in, wr_data_in,
        output mem_busy_out, mem_comp_out, mem_data_out
    );
endinterface

// File: rtl/d_line_mem_resp.sv
// ---------------------------------------------------------------------------
// d_line_mem_resp
//
// Backing-memory responder beneath the data cache. Serves 128-bit line reads
// for refills and sub-line byte/half/word writes for write-through, against a
// line-organised array of 2**LINE_AW lines. The array is zeroed line by line
// after every reset before any request is accepted.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   bus        d_line_mem_resp_if.slave (requests in, busy/comp/data out)
//   rd_cnt_out saturating count of read completions   (D_LINE_MEM_STATS_EN)
//   wr_cnt_out saturating count of write completions  (D_LINE_MEM_STATS_EN)
//
// Parameters:
//   LINE_AW  line address width
//   RD_LAT   acceptance-to-completion latency of reads, 1..15
//   WR_LAT   acceptance-to-completion latency of writes, 1..15
//
// Optional feature: define D_LINE_MEM_STATS_EN to add the completion counters.
// ---------------------------------------------------------------------------
module d_line_mem_resp #(
    parameter int LINE_AW = 8,
    parameter int RD_LAT  = 4,
    parameter int WR_LAT  = 2
) (
    input  logic              clk,
    input  logic              reset,
`ifdef D_LINE_MEM_STATS_EN
    output logic [15:0]       rd_cnt_out,
    output logic [15:0]       wr_cnt_out,
`endif
    d_line_mem_resp_if.slave  bus
);

    localparam int         DEPTH   = 2 ** LINE_AW;
    localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_LAT - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_WAIT,
        ST_WR_WAIT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        BE_BYTE = 2'b00,
        BE_HALF = 2'b01,
        BE_WORD = 2'b10,
        BE_NOP  = 2'b11
    } byte_en_e;

    // Control state
    state_e             state_q,    state_d;
    logic [3:0]         lat_cnt_q,  lat_cnt_d;
    logic [LINE_AW-1:0] init_cnt_q, init_cnt_d;

    // Request fields captured at acceptance
    logic [LINE_AW-1:0] addr_q,  addr_d;
    logic [1:0]         off_q,   off_d;
    logic [1:0]         boff_q,  boff_d;
    byte_en_e           be_q,    be_d;
    logic [31:0]        wdata_q, wdata_d;

    // Registered outputs
    logic               comp_q,  comp_d;
    logic [127:0]       rdata_q, rdata_d;

    // Array and its single write port
    logic [127:0]       mem_q [DEPTH];
    logic               mem_we;
    logic [LINE_AW-1:0] mem_waddr;
    logic [127:0]       mem_wline;
    logic [127:0]       cur_line;
    logic [31:0]        merged_word;
    logic               fire_rd;
    logic               fire_wr;

    // ------------------------------------------------------------------
    // Next-state logic and request capture.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        init_cnt_d = init_cnt_q;
        addr_d     = addr_q;
        off_d      = off_q;
        boff_d     = boff_q;
        be_d       = be_q;
        wdata_d    = wdata_q;

        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == {LINE_AW{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (bus.w_mem_req_in || bus.r_mem_req_in) begin
                    addr_d  = bus.mem_addr_in;
                    off_d   = bus.blockoffset_in;
                    boff_d  = bus.byte_off_in;
                    be_d    = byte_en_e'(bus.byte_en_in);
                    wdata_d = bus.wr_data_in;
                end
                // Write wins a tie; the read stays pending until after DONE.
                if (bus.w_mem_req_in) begin
                    state_d   = ST_WR_WAIT;
                    lat_cnt_d = WR_LOAD;
                end else if (bus.r_mem_req_in) begin
                    state_d   = ST_RD_WAIT;
                    lat_cnt_d = RD_LOAD;
                end
            end

            ST_RD_WAIT, ST_WR_WAIT: begin
                if (lat_cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_INIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Completion and array datapath. The transaction completes on the edge
    // where the latency counter reaches zero, so the registered pulse lands
    // exactly LAT cycles after acceptance (with LAT=1 that is the acceptance
    // edge itself, hence working from the _d side of the control state).
    // ------------------------------------------------------------------
    assign cur_line = mem_q[addr_d];

    always_comb begin
        fire_rd     = (state_d == ST_RD_WAIT) && (lat_cnt_d == 4'd0);
        fire_wr     = (state_d == ST_WR_WAIT) && (lat_cnt_d == 4'd0);
        comp_d      = fire_rd || fire_wr;
        rdata_d     = rdata_q;
        mem_we      = 1'b0;
        mem_waddr   = addr_d;
        mem_wline   = cur_line;
        merged_word = cur_line[{off_d, 5'd0} +: 32];

        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt_q;
            mem_wline = '0;
        end else if (fire_rd) begin
            rdata_d = cur_line;
        end else if (fire_wr) begin
            case (be_d)
                BE_BYTE: merged_word[{boff_d, 3'd0} +: 8]     = wdata_d[7:0];
                // Half-word lanes are always even; byte_off_in[0] is dropped.
                BE_HALF: merged_word[{boff_d[1], 4'd0} +: 16] = wdata_d[15:0];
                BE_WORD: merged_word                          = wdata_d;
                default: ;
            endcase
            mem_wline[{off_d, 5'd0} +: 32] = merged_word;
            mem_we = (be_d != BE_NOP);
        end

        // An aborted transaction must not leave a partial write behind.
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            lat_cnt_q  <= 4'd0;
            init_cnt_q <= '0;
            addr_q     <= '0;
            off_q      <= 2'd0;
            boff_q     <= 2'd0;
            be_q       <= BE_BYTE;
            wdata_q    <= 32'd0;
            comp_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            init_cnt_q <= init_cnt_d;
            addr_q     <= addr_d;
            off_q      <= off_d;
            boff_q     <= boff_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            comp_q     <= comp_d;
            rdata_q    <= rdata_d;
        end
    end

    // NOTE: the array has no reset branch so it maps onto RAM; the INIT
    // sweep zeroes it one line per cycle instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wline;
        end
    end

    assign bus.mem_busy_out = (state_q != ST_IDLE);
    assign bus.mem_comp_out = comp_q;
    assign bus.mem_data_out = rdata_q;

`ifdef D_LINE_MEM_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    // No-op writes still complete, so they are counted too.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (fire_rd && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (fire_wr && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt_out = rd_cnt_q;
    assign wr_cnt_out = wr_cnt_q;
`endif

endmodule

// File: doc/d_line_mem_resp.md
Name: d_line_mem_resp

Overview:
- Backing-memory responder on the data-cache miss/fill interface. The cache controller is the initiator; this block is the responder.
- Serves 128-bit line reads (cache refill) and sub-line word/half/byte writes (write-through) against a line-organised memory array.
- Fixed programmable latencies, a level-request/pulse-completion handshake, and power-on clear of the array.
- Replaces the flat memory model beneath the cache top.

Parameters:
- LINE_AW, 8, line address width; array depth = 2**LINE_AW lines
- RD_LAT, 4, cycles from read acceptance to mem_comp_out; legal range 1..15
- WR_LAT, 2, cycles from write acceptance to mem_comp_out; legal range 1..15

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- r_mem_req_in  in  1  line read request, level, held until completion
- w_mem_req_in  in  1  write request, level, held until completion
- mem_addr_in  in  LINE_AW  line address
- blockoffset_in  in  2  word select within line (write only)
- byte_off_in  in  2  byte offset within word (write only)
- byte_en_in  in  2  00 byte, 01 half, 10 word, 11 no-op
- wr_data_in  in  32  write data, right-justified
- mem_busy_out  out  1  high in any state other than IDLE
- mem_comp_out  out  1  one-cycle completion pulse
- mem_data_out  out  128  read line; word0 = [31:0]

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: mem_comp_out=0, mem_data_out=0, mem_busy_out=1 (INIT is entered). Counters clear to 0. Reset asserted mid-operation aborts any transaction with no completion, then restarts INIT.
- FSM states: INIT, IDLE, RD_WAIT, WR_WAIT, DONE.
- INIT: sweeps the init counter 0..2**LINE_AW-1, writing zero to one line per cycle, then goes to IDLE. Requests arriving during INIT are not accepted; they stay pending and are accepted in IDLE.
- IDLE, acceptance: a request is accepted on the first edge in IDLE where a request is high. On acceptance, latch address, offsets, byte_en and data, and load the latency counter with LAT-1.
- Simultaneous requests: if r and w are both high, the write is accepted first. The read stays pending and is accepted after DONE.
- RD_WAIT / WR_WAIT: the counter decrements each cycle. At 0:
  - read: the array line is registered into mem_data_out;
  - write: the merged word is committed to the array;
  - either way, mem_comp_out pulses for exactly one cycle and the FSM moves to DONE.
- Latency: accepted at edge t, mem_comp_out is high in the cycle following edge t+LAT-1, i.e. LAT cycles after acceptance.
- DONE: one mandatory idle cycle so the initiator can drop its request. DONE goes to IDLE unconditionally. A request still high in IDLE is treated as a new request.
- mem_data_out holds its value until the next read completion; writes do not change it.
- Write merge: read-modify-write of the target word.
  - byte: lane byte_off_in gets wr_data_in[7:0];
  - half: lanes {byte_off_in[1],0} and +1 get wr_data_in[15:0], so odd offsets are forced even;
  - word: the whole word is replaced and byte_off_in is ignored;
  - 11: no array change, but completion still pulses after WR_LAT.
- Ordering: a read accepted after a write completes returns the written data. No bypass is needed because requests are strictly sequential.
- Request drop: if the request drops while in a WAIT state, the transaction still completes. Inputs are sampled only at acceptance.
- Counter width: 4 bits.

Optional Feature:
- Macro: D_LINE_MEM_STATS_EN.
- When defined, adds outputs rd_cnt_out[15:0] and wr_cnt_out[15:0]. Each counts completions of its type, saturates at 0xFFFF, and clears on reset. The write count includes no-op writes.
- When not defined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then wait: mem_busy_out=1 for exactly 256 cycles after reset release, then 0. A read of line 0xFF returns 128'h0.
- Write line 0x12, offset 2, word 0xDEADBEEF, WR_LAT=2: mem_comp_out pulses 2 cycles after acceptance. A subsequent read of 0x12 returns data[95:64]=0xDEADBEEF, all other bits 0, with the pulse 4 cycles after acceptance.
- Byte and half writes to line 0x12, offset 0: byte 0xAB at byte_off 3, then half 0x1234 at byte_off 1 (forced to 0). Reading line 0x12 then gives word0=0xAB001234.
- Simultaneous r_mem_req_in and w_mem_req_in to line 0x05 with word 0x11111111: the write completes first, then the read returns word0=0x11111111. Exactly 2 completion pulses, separated by at least one DONE cycle.
- Reset asserted during RD_WAIT (counter=2): no mem_comp_out pulse, mem_data_out=0, INIT reruns, and the array reads back 0.
- With D_LINE_MEM_STATS_EN defined: 3 reads and 2 writes (one of them byte_en=11) give rd_cnt_out=3 and wr_cnt_out=2.
